// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//   Final pipeline stage. Picks the load result or the ALU result from the
//   MEMWB bundle and drives the register-file write port plus the WB->EX
//   forwarding registers. Instructions with side effects are sequenced here:
//   a deferred store is committed first (st_req/st_ack), then an ecall is
//   serviced (ecall_req/ecall_ack). Upstream is held off with WB_stall until
//   each side effect has been acknowledged.
//
// Ports
//   clk, reset               clock (posedge) / asynchronous active-low reset
//   MEMWB_*, memwb_*,        incoming bundle from the memory stage
//   dataselect
//   WB_stall                 stage busy, upstream must hold its bundle
//   rf_wen/waddr/wdata       register-file write port (one-cycle pulses)
//   WBEX_rd/rdval/wbactive   forwarding copy of the last register write
//   st_req/addr/value/size   store commit request, fields held while pending
//   st_ack                   store committed
//   ecall_req                ecall service request
//   ecall_ack, ecall_ret     ecall done, return value valid with the ack
//   instret                  retired-instruction counter
// ---------------------------------------------------------------------------
module writeback_stage #(
   parameter int DATA_WIDTH    = 64,
   parameter int RD_WIDTH      = 6,
   parameter int ECALL_RET_REG = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MEMWB_ready,
   input  logic                  MEMWB_wbactive,
   input  logic [RD_WIDTH-1:0]   memwb_rd,
   input  logic [DATA_WIDTH-1:0] memwb_aluresult,
   input  logic [DATA_WIDTH-1:0] memwb_loadeddata,
   input  logic                  dataselect,
   input  logic                  MEMWB_ecall,
   input  logic                  MEMWB_pend_write,
   input  logic [3:0]            MEMWB_size,
   input  logic [DATA_WIDTH-1:0] MEMWB_value,
   input  logic [DATA_WIDTH-1:0] MEMWB_addr,
   output logic                  WB_stall,
   output logic                  rf_wen,
   output logic [RD_WIDTH-1:0]   rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic [RD_WIDTH-1:0]   WBEX_rd,
   output logic [DATA_WIDTH-1:0] WBEX_rdval,
   output logic                  WBEX_wbactive,
   output logic                  st_req,
   output logic [DATA_WIDTH-1:0] st_addr,
   output logic [DATA_WIDTH-1:0] st_value,
   output logic [3:0]            st_size,
   input  logic                  st_ack,
   output logic                  ecall_req,
   input  logic                  ecall_ack,
   input  logic [DATA_WIDTH-1:0] ecall_ret,
   output logic [63:0]           instret
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STORE = 2'd1,
      ECALL = 2'd2
   } state_t;

   localparam logic [RD_WIDTH-1:0] RET_REG = RD_WIDTH'(ECALL_RET_REG);

   state_t                state;
   state_t                state_nxt;
   logic                  ecall_lat;
   logic                  accept;
   logic                  wr_plain;
   logic                  wr_ret;
   logic                  retire;
   logic [DATA_WIDTH-1:0] wd;

   assign WB_stall  = (state != IDLE);
   assign accept    = MEMWB_ready & ~WB_stall;
   assign wd        = dataselect ? memwb_loadeddata : memwb_aluresult;

   // Requests come straight from the registered state, so an ack can only
   // count once the state has been entered; acks seen with the request low
   // fall through the decode below.
   assign st_req    = (state == STORE);
   assign ecall_req = (state == ECALL);

   assign wr_ret    = ecall_req & ecall_ack;
   assign wr_plain  = accept & MEMWB_wbactive & (memwb_rd != '0);

   // Side-effect instructions retire on their last ack, everything else on accept.
   assign retire = (accept & ~MEMWB_pend_write & ~MEMWB_ecall)
                 | (st_req & st_ack & ~ecall_lat)
                 | wr_ret;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept && MEMWB_pend_write) begin
               state_nxt = STORE;
            end else if (accept && MEMWB_ecall) begin
               state_nxt = ECALL;
            end
         end
         STORE: begin
            if (st_ack) begin
               state_nxt = ecall_lat ? ECALL : IDLE;
            end
         end
         ECALL: begin
            if (ecall_ack) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Register-file write port and forwarding copy. The ecall return write
   // cannot collide with an accept because WB_stall is high in the ack cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf_wen        <= 1'b0;
         rf_waddr      <= '0;
         rf_wdata      <= '0;
         WBEX_rd       <= '0;
         WBEX_rdval    <= '0;
         WBEX_wbactive <= 1'b0;
      end else begin
         rf_wen <= wr_ret | wr_plain;
         if (wr_ret) begin
            rf_waddr      <= RET_REG;
            rf_wdata      <= ecall_ret;
            WBEX_rd       <= RET_REG;
            WBEX_rdval    <= ecall_ret;
            WBEX_wbactive <= 1'b1;
         end else if (wr_plain) begin
            rf_waddr      <= memwb_rd;
            rf_wdata      <= wd;
            WBEX_rd       <= memwb_rd;
            WBEX_rdval    <= wd;
            WBEX_wbactive <= 1'b1;
         end
      end
   end

   // Store fields and the pending-ecall flag are captured once at accept and
   // held untouched for the whole STORE phase.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_addr   <= '0;
         st_value  <= '0;
         st_size   <= '0;
         ecall_lat <= 1'b0;
      end else if (accept && MEMWB_pend_write) begin
         st_addr   <= MEMWB_addr;
         st_value  <= MEMWB_value;
         st_size   <= MEMWB_size;
         ecall_lat <= MEMWB_ecall;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instret <= '0;
      end else begin
         instret <= instret + 64'(retire);
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

   logic        clk;
   logic        reset;
   logic        MEMWB_ready;
   logic        MEMWB_wbactive;
   logic [5:0]  memwb_rd;
   logic [63:0] memwb_aluresult;
   logic [63:0] memwb_loadeddata;
   logic        dataselect;
   logic        MEMWB_ecall;
   logic        MEMWB_pend_write;
   logic [3:0]  MEMWB_size;
   logic [63:0] MEMWB_value;
   logic [63:0] MEMWB_addr;
   logic        WB_stall;
   logic        rf_wen;
   logic [5:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic [5:0]  WBEX_rd;
   logic [63:0] WBEX_rdval;
   logic        WBEX_wbactive;
   logic        st_req;
   logic [63:0] st_addr;
   logic [63:0] st_value;
   logic [3:0]  st_size;
   logic        st_ack;
   logic        ecall_req;
   logic        ecall_ack;
   logic [63:0] ecall_ret;
   logic [63:0] instret;

   writeback_stage dut (
      .clk              (clk),
      .reset            (reset),
      .MEMWB_ready      (MEMWB_ready),
      .MEMWB_wbactive   (MEMWB_wbactive),
      .memwb_rd         (memwb_rd),
      .memwb_aluresult  (memwb_aluresult),
      .memwb_loadeddata (memwb_loadeddata),
      .dataselect       (dataselect),
      .MEMWB_ecall      (MEMWB_ecall),
      .MEMWB_pend_write (MEMWB_pend_write),
      .MEMWB_size       (MEMWB_size),
      .MEMWB_value      (MEMWB_value),
      .MEMWB_addr       (MEMWB_addr),
      .WB_stall         (WB_stall),
      .rf_wen           (rf_wen),
      .rf_waddr         (rf_waddr),
      .rf_wdata         (rf_wdata),
      .WBEX_rd          (WBEX_rd),
      .WBEX_rdval       (WBEX_rdval),
      .WBEX_wbactive    (WBEX_wbactive),
      .st_req           (st_req),
      .st_addr          (st_addr),
      .st_value         (st_value),
      .st_size          (st_size),
      .st_ack           (st_ack),
      .ecall_req        (ecall_req),
      .ecall_ack        (ecall_ack),
      .ecall_ret        (ecall_ret),
      .instret          (instret)
   );

   typedef struct {
      logic [5:0]  rd;
      logic [63:0] d;
   } wr_t;

   typedef struct {
      logic [63:0] a;
      logic [63:0] v;
      logic [3:0]  s;
      bit          ec;
   } st_t;

   int          cmp_n = 0;
   int          err_n = 0;
   wr_t         wr_q[$];
   st_t         st_q[$];
   int          ecall_exp   = 0;
   logic [63:0] exp_instret = '0;
   bit          inc_pending = 1'b0;
   bit          chk_idle    = 1'b0;
   bit          manual      = 1'b0;
   bit          use_fix     = 1'b0;
   logic [63:0] ret_fix     = '0;
   int          cnt = 0, dly = 2, ecnt = 0, edly = 2;
   int          stall_waits = 0;
   int          wen_cnt     = 0;
   logic [5:0]  last_rd  = '0;
   logic [63:0] last_val = '0;
   logic        last_act = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor + store/ecall responder, working on the falling edge.
   initial begin : mon
      wr_t e;
      st_t cur;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (inc_pending) begin
               exp_instret++;
               inc_pending = 1'b0;
            end
            if (rf_wen) begin
               wen_cnt++;
               if (wr_q.size() == 0) begin
                  cmp_n++;
                  err_n++;
                  $display("FAIL rf_unexpected: got write x%0d=0x%0h expected no write", rf_waddr, rf_wdata);
               end else begin
                  e = wr_q.pop_front();
                  chk("rf_waddr", 64'(rf_waddr), 64'(e.rd));
                  chk("rf_wdata", rf_wdata, e.d);
                  last_rd  = e.rd;
                  last_val = e.d;
                  last_act = 1'b1;
               end
            end
            chk("WBEX_rd", 64'(WBEX_rd), 64'(last_rd));
            chk("WBEX_rdval", WBEX_rdval, last_val);
            chk("WBEX_wbactive", 64'(WBEX_wbactive), 64'(last_act));
            chk("instret", instret, exp_instret);
            if (chk_idle) begin
               chk("idle_after_ack", 64'(WB_stall), 64'(0));
               chk_idle = 1'b0;
            end
            if (!manual) begin
               st_ack    = 1'b0;
               ecall_ack = 1'b0;
               ecall_ret = {$urandom, $urandom};
               if (st_req) begin
                  ecall_ack = ($urandom_range(0, 1) == 1);
                  if (st_q.size() == 0) begin
                     cmp_n++;
                     err_n++;
                     $display("FAIL st_unexpected: got st_req=1 expected 0");
                  end else begin
                     cur = st_q[0];
                     chk("st_addr", st_addr, cur.a);
                     chk("st_value", st_value, cur.v);
                     chk("st_size", 64'(st_size), 64'(cur.s));
                     chk("ecall_req_in_store", 64'(ecall_req), 64'(0));
                     cnt++;
                     if (cnt >= dly) begin
                        st_ack = 1'b1;
                        cnt    = 0;
                        dly    = int'($urandom_range(2, 4));
                        void'(st_q.pop_front());
                        if (cur.ec) begin
                           ecall_exp++;
                        end else begin
                           inc_pending = 1'b1;
                           chk_idle    = 1'b1;
                        end
                     end
                  end
               end else if (ecall_req) begin
                  st_ack = ($urandom_range(0, 1) == 1);
                  if (ecall_exp == 0) begin
                     cmp_n++;
                     err_n++;
                     $display("FAIL ecall_unexpected: got ecall_req=1 expected 0");
                  end else begin
                     ecnt++;
                     if (ecnt >= edly) begin
                        if (use_fix) ecall_ret = ret_fix;
                        ecall_ack = 1'b1;
                        ecnt      = 0;
                        edly      = int'($urandom_range(2, 4));
                        ecall_exp--;
                        wr_q.push_back(wr_t'{6'd10, ecall_ret});
                        inc_pending = 1'b1;
                        chk_idle    = 1'b1;
                     end
                  end
               end else begin
                  // Acks with no request outstanding must be ignored.
                  st_ack    = ($urandom_range(0, 3) == 0);
                  ecall_ack = ($urandom_range(0, 3) == 0);
               end
            end
         end
      end
   end

   task automatic issue(input bit wba, input logic [5:0] rd, input logic [63:0] alu,
                        input logic [63:0] ld, input bit dsel, input bit ec, input bit pw,
                        input logic [63:0] addr, input logic [63:0] val, input logic [3:0] sz);
      int w;
      w = 0;
      MEMWB_ready      = 1'b1;
      MEMWB_wbactive   = wba;
      memwb_rd         = rd;
      memwb_aluresult  = alu;
      memwb_loadeddata = ld;
      dataselect       = dsel;
      MEMWB_ecall      = ec;
      MEMWB_pend_write = pw;
      MEMWB_addr       = addr;
      MEMWB_value      = val;
      MEMWB_size       = sz;
      @(negedge clk);
      while (WB_stall) begin
         w++;
         if (w > 100) begin
            cmp_n++;
            err_n++;
            $display("FAIL accept_timeout: WB_stall held %0d cycles, expected release", w);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
            $fatal(1, "accept timeout");
         end
         @(negedge clk);
      end
      if (wba && rd != 6'd0) wr_q.push_back(wr_t'{rd, dsel ? ld : alu});
      if (pw) st_q.push_back(st_t'{addr, val, sz, ec});
      else if (ec) ecall_exp++;
      @(posedge clk);
      #1;
      if (!pw && !ec) exp_instret++;
      stall_waits += w;
      MEMWB_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         MEMWB_ready      = 1'b0;
         MEMWB_wbactive   = 1'b1;
         memwb_rd         = 6'($urandom_range(1, 63));
         memwb_aluresult  = {$urandom, $urandom};
         MEMWB_ecall      = ($urandom_range(0, 1) == 1);
         MEMWB_pend_write = ($urandom_range(0, 1) == 1);
         MEMWB_addr       = {$urandom, $urandom};
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rand_issue();
      logic [3:0] sz;
      sz = 4'(1 << $urandom_range(0, 3));
      issue($urandom_range(0, 3) != 0,
            ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
            {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) == 0,
            {$urandom, $urandom}, {$urandom, $urandom}, sz);
   endtask

   task automatic wait_idle(output int nst);
      bit done;
      done = 1'b0;
      nst  = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (st_req) nst++;
         if (!WB_stall) done = 1'b1;
      end
      if (!done) begin
         cmp_n++;
         err_n++;
         $display("FAIL idle_timeout: WB_stall=1 after 200 cycles, expected 0");
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
         $fatal(1, "idle timeout");
      end
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      int n, w0, c0;
      logic [63:0] i0;
      reset = 1'b1;
      MEMWB_ready = 1'b0; MEMWB_wbactive = 1'b0; memwb_rd = '0;
      memwb_aluresult = '0; memwb_loadeddata = '0; dataselect = 1'b0;
      MEMWB_ecall = 1'b0; MEMWB_pend_write = 1'b0; MEMWB_size = '0;
      MEMWB_value = '0; MEMWB_addr = '0;
      st_ack = 1'b0; ecall_ack = 1'b0; ecall_ret = '0;
      #2 reset = 1'b0;
      #20;
      chk("rst_WB_stall", 64'(WB_stall), 64'(0));
      chk("rst_rf_wen", 64'(rf_wen), 64'(0));
      chk("rst_rf_waddr", 64'(rf_waddr), 64'(0));
      chk("rst_rf_wdata", rf_wdata, 64'(0));
      chk("rst_WBEX_rd", 64'(WBEX_rd), 64'(0));
      chk("rst_WBEX_rdval", WBEX_rdval, 64'(0));
      chk("rst_WBEX_wbactive", 64'(WBEX_wbactive), 64'(0));
      chk("rst_st_req", 64'(st_req), 64'(0));
      chk("rst_st_addr", st_addr, 64'(0));
      chk("rst_st_value", st_value, 64'(0));
      chk("rst_st_size", 64'(st_size), 64'(0));
      chk("rst_ecall_req", 64'(ecall_req), 64'(0));
      chk("rst_instret", instret, 64'(0));
      @(negedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;

      // plain ALU op into x5
      issue(1, 6'd5, 64'h1234, 64'hDEAD, 0, 0, 0, 64'h0, 64'h0, 4'd0);
      idle(2);
      chk("alu_instret", instret, 64'd1);
      chk("alu_fwd", WBEX_rdval, 64'h1234);

      // load into x0 is dropped but still retires
      c0 = wen_cnt;
      issue(1, 6'd0, 64'h55, 64'hFF, 1, 0, 0, 64'h0, 64'h0, 4'd0);
      idle(2);
      chk("x0_no_write", 64'(wen_cnt - c0), 64'd0);
      chk("x0_instret", instret, 64'd2);

      // deferred store, acked on its third request cycle
      dly = 3;
      cnt = 0;
      issue(0, 6'd0, 64'h0, 64'h0, 0, 0, 1, 64'h8000, 64'hAB, 4'd1);
      wait_idle(n);
      chk("store_req_cycles", 64'(n), 64'd3);
      chk("store_instret", instret, 64'd3);

      // store followed by ecall returning 7
      use_fix = 1'b1;
      ret_fix = 64'h7;
      issue(1, 6'd9, 64'h99, 64'h0, 0, 1, 1, 64'h9000, 64'hCD, 4'd8);
      wait_idle(n);
      idle(1);
      use_fix = 1'b0;
      chk("ecall_x10", WBEX_rdval, 64'h7);
      chk("ecall_rd", 64'(WBEX_rd), 64'd10);

      // four back-to-back plain ops
      w0 = stall_waits;
      c0 = wen_cnt;
      i0 = exp_instret;
      for (int k = 1; k <= 4; k++) begin
         issue(1, 6'(k), 64'(k * 16), 64'h0, 0, 0, 0, 64'h0, 64'h0, 4'd0);
      end
      idle(2);
      chk("b2b_no_stall", 64'(stall_waits - w0), 64'd0);
      chk("b2b_writes", 64'(wen_cnt - c0), 64'd4);
      chk("b2b_instret", instret, i0 + 64'd4);

      // randomized traffic
      for (int k = 0; k < 300; k++) begin
         rand_issue();
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
      wait_idle(n);
      idle(3);
      chk("drain_wr_q", 64'(wr_q.size()), 64'd0);
      chk("drain_st_q", 64'(st_q.size()), 64'd0);
      chk("drain_ecall", 64'(ecall_exp), 64'd0);

      // reset while an ecall is outstanding
      manual    = 1'b1;
      st_ack    = 1'b0;
      ecall_ack = 1'b0;
      issue(0, 6'd0, 64'h0, 64'h0, 0, 1, 0, 64'h0, 64'h0, 4'd0);
      n = 0;
      while (!ecall_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ecall_pending", 64'(ecall_req), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst_ecall_req", 64'(ecall_req), 64'd0);
      chk("arst_stall", 64'(WB_stall), 64'd0);
      chk("arst_instret", instret, 64'd0);
      wr_q.delete();
      st_q.delete();
      ecall_exp = 0; exp_instret = '0; inc_pending = 1'b0; chk_idle = 1'b0;
      cnt = 0; ecnt = 0;
      last_rd = '0; last_val = '0; last_act = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      ecall_ret = 64'h4242;
      ecall_ack = 1'b1;
      @(negedge clk);
      ecall_ack = 1'b0;
      c0 = wen_cnt;
      repeat (2) @(negedge clk);
      chk("late_ack_no_write", 64'(wen_cnt - c0), 64'd0);
      chk("late_ack_instret", instret, 64'd0);
      chk("late_ack_stall", 64'(WB_stall), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end

endmodule
